attn_inst_sequencer: RTL and testbench

//  Autonomous driver of the 20-bit fullchip instruction word and the core0/core1 mem_in buses.

---
 rtl/attn_inst_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_attn_inst_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_inst_sequencer.sv
// Autonomous attention-flow sequencer. It accepts Q/K vectors from the host over valid/ready
// and then replays the full fullchip instruction stream. All outputs are registered.
module attn_inst_sequencer #(
  parameter int unsigned bw          = 8,
  parameter int unsigned pr          = 16,
  parameter int unsigned col         = 8,
  parameter int unsigned total_cycle = 16,
  parameter int unsigned WAIT_CYC    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [3:0]        phase,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [pr*bw-1:0]  in_data_core0,
  input  logic [pr*bw-1:0]  in_data_core1,
  output logic [pr*bw-1:0]  mem_in_core0,
  output logic [pr*bw-1:0]  mem_in_core1,
  output logic [19:0]       inst
);

  typedef enum logic [3:0] {
    StIdle, StQwr, StKwr, StPause, StLoad, StExec, StDrain, StFetch, StSum, StNorm, StWb, StDone
  } state_e;

  // Phase counter also walks through each phase's trailing GAP/WAIT cycles.
  localparam int unsigned QW = 6;
  localparam logic [QW-1:0] QTot  = QW'(total_cycle);
  localparam logic [QW-1:0] QCol  = QW'(col);
  localparam logic [QW-1:0] QWait = QW'(WAIT_CYC);
  localparam logic [QW-1:0] QOne  = QW'(1);
  localparam logic [QW-1:0] QTwo  = QW'(2);

  // inst bit positions
  localparam int unsigned BExtRd = 19, BDiv = 18, BAcc = 17, BOfifoRd = 16;
  localparam int unsigned BExec = 7, BLoad = 6, BQRd = 5, BQWr = 4, BKRd = 3, BKWr = 2;
  localparam int unsigned BPRd = 1, BPWr = 0;

  state_e          state_q, state_d;
  logic [QW-1:0]   q_q, q_d, q_m1;
  logic [19:0]     inst_d;
  logic            in_ready_d;
  logic            hs;
  logic            wr_vec;

  // Next-state, phase counter and next instruction word.
  always_comb begin
    state_d = state_q;
    q_d     = q_q + QOne;
    q_m1    = q_q - QOne;
    inst_d  = '0;
    hs      = in_valid & in_ready;
    unique case (state_q)
      StIdle: begin
        q_d = '0;
        if (start) state_d = StQwr;
      end
      StQwr: begin
        if (q_q < QTot) begin
          q_d = q_q;
          if (hs) begin
            q_d            = q_q + QOne;
            inst_d[BQWr]   = 1'b1;
            inst_d[15:12]  = q_q[3:0];
          end
        end else begin
          state_d = StKwr;
          q_d     = '0;
        end
      end
      StKwr: begin
        if (q_q < QCol) begin
          q_d = q_q;
          if (hs) begin
            q_d            = q_q + QOne;
            inst_d[BKWr]   = 1'b1;
            inst_d[15:12]  = q_q[3:0];
          end
        end else begin
          state_d = StPause;
          q_d     = '0;
        end
      end
      StPause: begin
        if (q_q == QOne) begin
          state_d = StLoad;
          q_d     = '0;
        end
      end
      StLoad: begin
        if (q_q <= QCol) begin
          inst_d[BLoad] = 1'b1;
          inst_d[BKRd]  = (q_q >= QOne);
          if (q_q >= QTwo) inst_d[15:12] = q_m1[3:0];
        end else if (q_q == QCol + QOne) begin
          inst_d[BLoad] = 1'b1;
        end else if (q_q == QCol + QTwo + QWait) begin
          state_d = StExec;
          q_d     = '0;
        end
      end
      StExec: begin
        if (q_q < QTot) begin
          inst_d[BExec] = 1'b1;
          inst_d[BQRd]  = 1'b1;
          inst_d[15:12] = q_q[3:0];
        end else if (q_q == QTot + QWait) begin
          state_d = StDrain;
          q_d     = '0;
        end
      end
      StDrain, StWb: begin
        if (q_q < QTot) begin
          inst_d[BOfifoRd] = 1'b1;
          inst_d[BPWr]     = 1'b1;
          inst_d[11:8]     = q_q[3:0];
        end else begin
          state_d = (state_q == StDrain) ? StFetch : StDone;
          q_d     = '0;
        end
      end
      StFetch: begin
        if (q_q < QTot) begin
          inst_d[BPRd]  = 1'b1;
          inst_d[11:8]  = q_q[3:0];
          inst_d[BAcc]  = (q_q != '0);
        end else if (q_q == QTot) begin
          inst_d[BAcc] = 1'b1;
        end else begin
          state_d = StSum;
          q_d     = '0;
        end
      end
      StSum, StNorm: begin
        if (q_q < QTot) begin
          inst_d[BExtRd] = (state_q == StSum);
          inst_d[BDiv]   = (state_q == StNorm);
        end else begin
          state_d = (state_q == StSum) ? StNorm : StWb;
          q_d     = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        q_d     = '0;
      end
      default: begin
        state_d = StIdle;
        q_d     = '0;
      end
    endcase
    in_ready_d = ((state_d == StQwr) && (q_d < QTot)) || ((state_d == StKwr) && (q_d < QCol));
    wr_vec     = inst_d[BQWr] | inst_d[BKWr];
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      q_q          <= '0;
      inst         <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      phase        <= '0;
      mem_in_core0 <= '0;
      mem_in_core1 <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      inst     <= inst_d;
      in_ready <= in_ready_d;
      busy     <= (state_q != StIdle);
      done     <= (state_q == StDone);
      phase    <= state_q;
      if (wr_vec) begin
        mem_in_core0 <= in_data_core0;
        mem_in_core1 <= in_data_core1;
      end
    end
  end

endmodule

// File: tb/tb_attn_inst_sequencer.sv
// Scoreboard bench for attn_inst_sequencer: the expected instruction stream is derived from the
// phase description and queued at start; vector data is queued at each handshake.
module tb_attn_inst_sequencer;
  localparam int W = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, in_ready;
  logic [3:0]    phase;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data_core0 = '0;
  logic [W-1:0]  in_data_core1 = '0;
  logic [W-1:0]  mem_in_core0, mem_in_core1;
  logic [19:0]   inst;

  attn_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .phase(phase),
    .in_valid(in_valid), .in_ready(in_ready), .in_data_core0(in_data_core0),
    .in_data_core1(in_data_core1), .mem_in_core0(mem_in_core0), .mem_in_core1(mem_in_core1),
    .inst(inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [19:0]   exp_q[$];
  logic [W-1:0]  exp_d0[$];
  logic [W-1:0]  exp_d1[$];
  logic [W-1:0]  qv[16];
  logic [W-1:0]  k0v[8];
  logic [W-1:0]  k1v[8];

  bit mon_en = 1'b0;
  int cyc = 0;
  int qwr_first, qwr_last;
  int cnt[10];  // load kmem_rd execute ofifo_rd pmem_wr pmem_rd acc fifo_ext_rd div done

  // Advance to the next falling edge and score whatever the DUT presented.
  task automatic tick();
    logic [19:0]  ew;
    logic [W-1:0] e0, e1;
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (done) cnt[9]++;
      if (inst != 20'h0) begin
        if (inst[6]) cnt[0]++;
        if (inst[3]) cnt[1]++;
        if (inst[7]) cnt[2]++;
        if (inst[16]) cnt[3]++;
        if (inst[0]) cnt[4]++;
        if (inst[1]) cnt[5]++;
        if (inst[17]) cnt[6]++;
        if (inst[19]) cnt[7]++;
        if (inst[18]) cnt[8]++;
        if (inst[4]) begin
          if (qwr_first < 0) qwr_first = cyc;
          qwr_last = cyc;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL inst_extra: got %h required none", inst);
        end else begin
          ew = exp_q.pop_front();
          if (inst !== ew) begin
            errors++;
            $display("FAIL inst_word: got %h required %h", inst, ew);
          end
        end
        if (inst[4] | inst[2]) begin
          checks++;
          if (exp_d0.size() == 0) begin
            errors++;
            $display("FAIL mem_in_extra: got %h required none", mem_in_core0);
          end else begin
            e0 = exp_d0.pop_front();
            e1 = exp_d1.pop_front();
            if (mem_in_core0 !== e0 || mem_in_core1 !== e1) begin
              errors++;
              $display("FAIL mem_in: got %h/%h required %h/%h", mem_in_core0, mem_in_core1,
                       e0, e1);
            end
          end
        end
      end
    end
  endtask

  task automatic push_expect();
    logic [19:0] w;
    for (int i = 0; i < 16; i++) exp_q.push_back(20'h00010 | (20'(i) << 12));
    for (int i = 0; i < 8; i++) exp_q.push_back(20'h00004 | (20'(i) << 12));
    for (int i = 0; i < 10; i++) begin
      w = 20'h00040;
      if (i >= 1 && i <= 8) w = w | 20'h00008;
      if (i >= 2 && i <= 8) w = w | (20'(i - 1) << 12);
      exp_q.push_back(w);
    end
    for (int i = 0; i < 16; i++) exp_q.push_back(20'h000A0 | (20'(i) << 12));
    for (int i = 0; i < 16; i++) exp_q.push_back(20'h10001 | (20'(i) << 8));
    for (int i = 0; i < 16; i++)
      exp_q.push_back(20'h00002 | (20'(i) << 8) | ((i >= 1) ? 20'h20000 : 20'h0));
    exp_q.push_back(20'h20000);
    for (int i = 0; i < 16; i++) exp_q.push_back(20'h80000);
    for (int i = 0; i < 16; i++) exp_q.push_back(20'h40000);
    for (int i = 0; i < 16; i++) exp_q.push_back(20'h10001 | (20'(i) << 8));
  endtask

  // One full run. toggle: in_valid alternates; restart: pulse start during FETCH;
  // abort: assert reset when EXEC reaches address 5.
  task automatic run_flow(input bit toggle, input bit restart, input bit abort,
                          output bit aborted);
    int  idx = 0;
    bit  pulsed = 1'b0;
    bit  done_seen = 1'b0;
    bit  v;
    aborted = 1'b0;
    for (int i = 0; i < 10; i++) cnt[i] = 0;
    qwr_first = -1;
    qwr_last  = -1;
    for (int i = 0; i < 16; i++) qv[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      k0v[i] = {$urandom, $urandom, $urandom, $urandom};
      k1v[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    exp_q.delete(); exp_d0.delete(); exp_d1.delete();
    push_expect();
    mon_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 800 && !done_seen; c++) begin
      if (idx < 24) begin
        v = toggle ? (c % 2 == 0) : 1'b1;
        in_valid      = v;
        in_data_core0 = (idx < 16) ? qv[idx] : k0v[idx - 16];
        in_data_core1 = (idx < 16) ? qv[idx] : k1v[idx - 16];
        if (v && in_ready) begin
          exp_d0.push_back(in_data_core0);
          exp_d1.push_back(in_data_core1);
          idx++;
        end
      end else begin
        in_valid = 1'b1;  // held high after the last vector; must be ignored
      end
      start = restart && !pulsed && inst[1];
      if (start) pulsed = 1'b1;
      tick();
      if (abort && inst[7] && inst[15:12] == 4'd5) begin
        aborted = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (done) done_seen = 1'b1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout: got no done required done within budget");
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: got busy=%b done=%b required 0/0", busy, done);
    end
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL inst_missing: got %0d words left required 0", exp_q.size());
    end
  endtask

  task automatic check_counts();
    int exp_cnt[10] = '{10, 8, 16, 32, 32, 16, 16, 16, 16, 1};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cnt[i] !== exp_cnt[i]) begin
        errors++;
        $display("FAIL count_%0d: got %0d required %0d", i, cnt[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (inst !== 20'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got inst=%h busy=%b rdy=%b required 0", inst, busy, in_ready);
      end
    end
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (inst !== 20'h0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset: got inst=%h busy=%b rdy=%b required 0", inst, busy, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ab;
    run_flow(1'b0, 1'b0, 1'b0, ab);
    checks++;
    if (qwr_last - qwr_first !== 15) begin
      errors++;
      $display("FAIL qwr_span: got %0d required 15", qwr_last - qwr_first);
    end
    checks++;
    if (mem_in_core0 !== k0v[7] || mem_in_core1 !== k1v[7]) begin
      errors++;
      $display("FAIL final_mem_in: got %h/%h required %h/%h", mem_in_core0, mem_in_core1,
               k0v[7], k1v[7]);
    end
    check_counts();
  endtask

  task automatic test_bubbles();
    bit ab;
    run_flow(1'b1, 1'b0, 1'b0, ab);
    checks++;
    if (qwr_last - qwr_first !== 30) begin
      errors++;
      $display("FAIL bubble_span: got %0d required 30", qwr_last - qwr_first);
    end
    check_counts();
  endtask

  task automatic test_reset_mid_run();
    bit ab;
    run_flow(1'b0, 1'b0, 1'b1, ab);
    checks++;
    if (!ab) begin
      errors++;
      $display("FAIL abort_point: got no EXEC addr 5 required one");
    end
    mon_en = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (inst !== 20'h0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got inst=%h busy=%b rdy=%b required 0", inst, busy, in_ready);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (inst !== 20'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got inst=%h busy=%b required 0", inst, busy);
    end
    run_flow(1'b0, 1'b0, 1'b0, ab);
    check_counts();
  endtask

  task automatic test_start_in_fetch();
    bit ab;
    run_flow(1'b0, 1'b1, 1'b0, ab);
    check_counts();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || inst !== 20'h0) begin
        errors++;
        $display("FAIL no_rerun: got busy=%b inst=%h required 0", busy, inst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_reset_mid_run();
    test_start_in_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
